pattern_count_engine: RTL and testbench

Hardware responder for the program-3 start/done handshake. On `req` it reads a 5-bit pattern and a 32-byte message from data memory, counts occurrences of the pattern three ways, writes the three counts back to data memory, and raises `done`. It sits beside `dm1` in `top_level` as a memory master and replaces the software loop for program 3.

---
 rtl/pattern_count_engine.sv | 190 +++++++++++++++++++
 tb/tb_pattern_count_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_count_engine.sv
// Pattern-count responder: reads a 5-bit pattern and a message, counts pattern hits
// three ways and writes the counts back. Optional byte-crossing count: PATCNT_CROSS_EN.
module pattern_count_engine #(
   parameter int NUM_BYTES = 32,
   parameter int PAT_ADDR  = 32,
   parameter int RES_ADDR  = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   output logic       done,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data
);

   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
   localparam logic [7:0] PAT_A  = 8'(PAT_ADDR);
   localparam logic [7:0] RES_A0 = 8'(RES_ADDR);
   localparam logic [7:0] RES_A1 = 8'(RES_ADDR + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SCAN = 3'd2,
      WR0  = 3'd3,
      WR1  = 3'd4,
`ifdef PATCNT_CROSS_EN
      WR2  = 3'd5,
`endif
      DONE = 3'd6
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [IDX_W-1:0] idx_reg;
   logic [4:0]       pat_reg;
   logic [7:0]       ctb_reg;
   logic [7:0]       cto_reg;

   // Windows fully inside the current byte
   logic [3:0] byte_hit;
   logic [2:0] byte_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_win
         assign byte_hit[gi] = (mem_rd_data[gi +: 5] == pat_reg);
      end
   endgenerate

   always_comb begin
      byte_cnt = '0;
      for (int k = 0; k < 4; k++) begin
         byte_cnt = byte_cnt + {2'b00, byte_hit[k]};
      end
   end

`ifdef PATCNT_CROSS_EN
   localparam logic [7:0] RES_A2 = 8'(RES_ADDR + 2);

   logic [7:0]  cts_reg;
   logic [7:0]  prev_reg;
   logic [15:0] win;
   logic [7:0]  cross_hit;
   logic [3:0]  cross_cnt;
   logic [7:0]  cts_add;

   assign win = {prev_reg, mem_rd_data};

   // The eight windows that start inside the previous byte
   generate
      for (gi = 0; gi < 8; gi++) begin : g_cross_win
         assign cross_hit[gi] = (win[15-gi -: 5] == pat_reg);
      end
   endgenerate

   always_comb begin
      cross_cnt = '0;
      for (int k = 0; k < 8; k++) begin
         cross_cnt = cross_cnt + {3'b000, cross_hit[k]};
      end
   end

   // Last byte also contributes the windows starting inside it, which are exactly byte_hit
   always_comb begin
      cts_add = '0;
      if (idx_reg != '0) begin
         cts_add = cts_add + {4'b0000, cross_cnt};
      end
      if (idx_reg == LAST_IDX) begin
         cts_add = cts_add + {5'b00000, byte_cnt};
      end
   end
`endif

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (req) state_next = LOAD;
         LOAD:    state_next = SCAN;
         SCAN:    if (idx_reg == LAST_IDX) state_next = WR0;
         WR0:     state_next = WR1;
`ifdef PATCNT_CROSS_EN
         WR1:     state_next = WR2;
         WR2:     state_next = DONE;
`else
         WR1:     state_next = DONE;
`endif
         DONE:    if (req) state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         pat_reg   <= '0;
         ctb_reg   <= '0;
         cto_reg   <= '0;
`ifdef PATCNT_CROSS_EN
         cts_reg   <= '0;
         prev_reg  <= '0;
`endif
      end else begin
         state_reg <= state_next;
         unique case (state_reg)
            IDLE, DONE: begin
               if (req) begin
                  idx_reg  <= '0;
                  ctb_reg  <= '0;
                  cto_reg  <= '0;
`ifdef PATCNT_CROSS_EN
                  cts_reg  <= '0;
                  prev_reg <= '0;
`endif
               end
            end
            LOAD: pat_reg <= mem_rd_data[4:0];
            SCAN: begin
               ctb_reg <= ctb_reg + {5'b00000, byte_cnt};
               if (byte_cnt != '0) begin
                  cto_reg <= cto_reg + 8'd1;
               end
               idx_reg <= idx_reg + 1'b1;
`ifdef PATCNT_CROSS_EN
               cts_reg  <= cts_reg + cts_add;
               prev_reg <= mem_rd_data;
`endif
            end
            default: ;
         endcase
      end
   end

   // The write strobe is also held off while reset is asserted so an aborted run never commits
   always_comb begin
      done        = 1'b0;
      mem_addr    = 8'd0;
      mem_wr_en   = 1'b0;
      mem_wr_data = 8'd0;
      unique case (state_reg)
         LOAD: mem_addr = PAT_A;
         SCAN: mem_addr = 8'(idx_reg);
         WR0: begin
            mem_addr    = RES_A0;
            mem_wr_en   = reset;
            mem_wr_data = ctb_reg;
         end
         WR1: begin
            mem_addr    = RES_A1;
            mem_wr_en   = reset;
            mem_wr_data = cto_reg;
         end
`ifdef PATCNT_CROSS_EN
         WR2: begin
            mem_addr    = RES_A2;
            mem_wr_en   = reset;
            mem_wr_data = cts_reg;
         end
`endif
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Self-checking bench for pattern_count_engine: directed and random messages
// compared against a bit-string window model; reset abort and held-req restart.
module tb_pattern_count_engine;

`ifdef PATCNT_CROSS_EN
   localparam int LAT  = 37;
   localparam int NRES = 3;
`else
   localparam int LAT  = 36;
   localparam int NRES = 2;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   logic [7:0] image [0:255];
   logic [7:0] wmem  [0:255];
   logic       wm_clear;
   int         res_writes;
   int         w35_writes;

   logic [7:0] msg [32];
   logic [4:0] pat;
   int         ectb, ecto, ects;
   int         checks = 0;
   int         errors = 0;
   int         n, n2, highs;

   always #5 clk = ~clk;

   pattern_count_engine dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data)
   );

   assign mem_rd_data = image[mem_addr];

   always @(posedge clk) begin
      if (wm_clear) begin
         for (int a = 33; a <= 35; a++) wmem[a] <= 8'hAA;
         res_writes <= 0;
         w35_writes <= 0;
      end else if (mem_wr_en) begin
         wmem[mem_addr] <= mem_wr_data;
         if (mem_addr >= 8'd33 && mem_addr <= 8'd35) res_writes <= res_writes + 1;
         if (mem_addr == 8'd35) w35_writes <= w35_writes + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Message as one 256-bit string (bit 0 = MSB of byte 0); count every 5-bit window
   function automatic void model(output int m_ctb, output int m_cto, output int m_cts);
      bit   bits [256];
      int   per_byte;
      logic [4:0] v;
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 8; j++) bits[8*i+j] = msg[i][7-j];
      m_ctb = 0; m_cto = 0; m_cts = 0;
      for (int s = 0; s <= 251; s++) begin
         v = '0;
         for (int t = 0; t < 5; t++) v = {v[3:0], bits[s+t]};
         if (v == pat) m_cts++;
      end
      for (int i = 0; i < 32; i++) begin
         per_byte = 0;
         for (int o = 0; o < 4; o++) begin
            v = '0;
            for (int t = 0; t < 5; t++) v = {v[3:0], bits[8*i+o+t]};
            if (v == pat) per_byte++;
         end
         m_ctb += per_byte;
         if (per_byte > 0) m_cto++;
      end
   endfunction

   task automatic preload();
      for (int i = 0; i < 32; i++) image[i] = msg[i];
      image[32] = {3'($urandom), pat};
      wm_clear = 1'b1;
      @(posedge clk); #1;
      wm_clear = 1'b0;
   endtask

   task automatic wait_done(input bit hold, output int cyc);
      req = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1 && !hold) req = 1'b0;
      end while (!done && cyc < 200);
   endtask

   task automatic check_results(input string tag, input int e1, input int e2, input int e3);
      check({tag, ".ctb"}, 32'(wmem[33]), 32'(e1));
      check({tag, ".cto"}, 32'(wmem[34]), 32'(e2));
`ifdef PATCNT_CROSS_EN
      check({tag, ".cts"}, 32'(wmem[35]), 32'(e3));
`else
      check({tag, ".res2_kept"}, 32'(wmem[35]), 32'hAA);
      check({tag, ".res2_writes"}, 32'(w35_writes), 32'd0);
`endif
   endtask

   task automatic run_job(input string tag, input int e1, input int e2, input int e3);
      int cyc;
      preload();
      wait_done(1'b0, cyc);
      check({tag, ".latency"}, 32'(cyc), 32'(LAT));
      check_results(tag, e1, e2, e3);
      $display("job %s pat=%b ctb=%0d cto=%0d cts=%0d cycles=%0d", tag, pat,
               wmem[33], wmem[34], wmem[35], cyc);
      @(posedge clk); #1;
      check({tag, ".done_held"}, 32'(done), 32'd1);
   endtask

   task automatic fill_const(input logic [7:0] b);
      for (int i = 0; i < 32; i++) msg[i] = b;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
      pat = 5'($urandom);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) image[a] = 8'h00;
      reset    = 1'b0;
      req      = 1'b0;
      wm_clear = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset.done", 32'(done), 32'd0);
      check("reset.wr_en", 32'(mem_wr_en), 32'd0);
      check("reset.addr", 32'(mem_addr), 32'd0);
      check("reset.wr_data", 32'(mem_wr_data), 32'd0);
      wm_clear = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;

      fill_const(8'hC1); pat = 5'b00111; run_job("c1_p07", 0, 0, 31);
      fill_const(8'h00); pat = 5'b00000; run_job("zero", 128, 32, 252);
      fill_const(8'h55); pat = 5'b10101; run_job("alt55", 64, 32, 126);
      fill_const(8'hFF); pat = 5'b00111; run_job("ones", 0, 0, 0);

      for (int s = 0; s < 20; s++) begin
         fill_random();
         model(ectb, ecto, ects);
         run_job($sformatf("rand%0d", s), ectb, ecto, ects);
      end

      // Abort during SCAN, then confirm nothing is written and a fresh run is correct
      fill_random();
      preload();
      req = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         @(posedge clk); #1;
         if (c == 1) req = 1'b0;
      end
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("abort.done", 32'(done), 32'd0);
      check("abort.wr_en", 32'(mem_wr_en), 32'd0);
      check("abort.addr_idle", 32'(mem_addr), 32'd0);
      highs = 0;
      for (int c = 0; c < 45; c++) begin
         @(posedge clk); #1;
         if (done) highs++;
      end
      check("abort.no_done", 32'(highs), 32'd0);
      check("abort.no_writes", 32'(res_writes), 32'd0);
      $display("job abort: done_cycles=%0d result_writes=%0d", highs, res_writes);
      model(ectb, ecto, ects);
      run_job("after_abort", ectb, ecto, ects);

      // req held high: back-to-back runs with a one-cycle done
      fill_random();
      model(ectb, ecto, ects);
      preload();
      wait_done(1'b1, n);
      check("held.first_latency", 32'(n), 32'(LAT));
      check_results("held.first", ectb, ecto, ects);
      n2 = 0;
      highs = 1;
      do begin
         @(posedge clk); #1;
         n2++;
         if (n2 == 1) check("held.done_one_cycle", 32'(done), 32'd0);
      end while (!done && n2 < 200);
      req = 1'b0;
      check("held.interval", 32'(n2), 32'(LAT));
      check_results("held.second", ectb, ecto, ects);
      check("held.write_count", 32'(res_writes), 32'(2 * NRES));
      $display("job held: first=%0d interval=%0d ctb=%0d cto=%0d cts=%0d", n, n2,
               wmem[33], wmem[34], wmem[35]);
      @(posedge clk); #1;
      check("held.done_after_release", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
